// File: rtl/io_input_reader.sv
// io_input_reader: read side of the I/O mapper.
// Synchronizes and debounces the active-low cabinet inputs and coin switches,
// latches coin insertions until read, and returns register data on read strobes.
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   ce          debounce tick (gates only the debounce counters)
//   raw_in      16 active-low inputs; port A = [7:0], port B = [15:8]
//   coin_n      2 active-low coin switches
//   cs, rd      chip select and read strobe (one accept per rising strobe)
//   addr        register select: 0 port A, 1 port B, 2 coin latches, 3 coin level
//   dout        registered read data, holds until the next read
//   dout_valid  one-clock pulse marking new dout
//   coin_irq    high while any coin latch is set
module io_input_reader #(
  parameter int unsigned DB_COUNT = 4,
  parameter int unsigned DBW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [15:0] raw_in,
  input  logic [1:0]  coin_n,
  input  logic        cs,
  input  logic        rd,
  input  logic [1:0]  addr,
  output logic [7:0]  dout,
  output logic        dout_valid,
  output logic        coin_irq
);

  localparam int unsigned NIN   = 18;
  localparam int unsigned NCOIN = 2;

  logic [NIN-1:0]   sync1;
  logic [NIN-1:0]   sync2;
  logic [NIN-1:0]   stable;
  logic [NIN-1:0]   stable_nxt;
  logic [DBW-1:0]   cnt     [NIN];
  logic [DBW-1:0]   cnt_nxt [NIN];
  logic [NCOIN-1:0] coin_latch;
  logic [NCOIN-1:0] coin_latch_nxt;
  logic [NCOIN-1:0] coin_fall;
  logic             req;
  logic             req_q;
  logic             accept;
  logic             pend;
  logic [7:0]       rd_data;
  logic [7:0]       mux;

  // Per-bit debounce: count ce ticks of disagreement, adopt sync value on the last one
  always_comb begin
    for (int i = 0; i < NIN; i++) begin
      stable_nxt[i] = stable[i];
      cnt_nxt[i]    = cnt[i];
      if (sync2[i] == stable[i]) begin
        cnt_nxt[i] = '0;
      end else if (ce) begin
        if (cnt[i] == DBW'(DB_COUNT - 1)) begin
          stable_nxt[i] = sync2[i];
          cnt_nxt[i]    = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + DBW'(1);
        end
      end
    end
  end

  // Read strobe edge detect
  always_comb begin
    req    = cs & rd;
    accept = req & ~req_q;
  end

  // Coin latch: falling stable edge sets on the same clock; a colliding read-clear loses
  always_comb begin
    coin_fall      = stable[NIN-1:NIN-2] & ~stable_nxt[NIN-1:NIN-2];
    coin_latch_nxt = coin_latch;
    if (accept && (addr == 2'd2)) begin
      coin_latch_nxt = '0;
    end
    coin_latch_nxt = coin_latch_nxt | coin_fall;
  end

  // Register read mux; addr 2 samples the latch before any clear
  always_comb begin
    mux = 8'hFF;
    case (addr)
      2'd0:    mux = stable[7:0];
      2'd1:    mux = stable[15:8];
      2'd2:    mux = {6'b0, coin_latch};
      default: mux = {6'b0, stable[NIN-1:NIN-2]};
    endcase
  end

  // All state; inputs idle high, so sync and stable reset to 1
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '1;
      sync2      <= '1;
      stable     <= '1;
      for (int i = 0; i < NIN; i++) cnt[i] <= '0;
      coin_latch <= '0;
      coin_irq   <= 1'b0;
      req_q      <= 1'b0;
      pend       <= 1'b0;
      rd_data    <= 8'hFF;
      dout       <= 8'hFF;
      dout_valid <= 1'b0;
    end else begin
      sync1      <= {coin_n, raw_in};
      sync2      <= sync1;
      stable     <= stable_nxt;
      for (int i = 0; i < NIN; i++) cnt[i] <= cnt_nxt[i];
      coin_latch <= coin_latch_nxt;
      coin_irq   <= |coin_latch;
      req_q      <= req;
      pend       <= accept;
      if (accept) begin
        rd_data <= mux;
      end
      if (pend) begin
        dout <= rd_data;
      end
      dout_valid <= pend;
    end
  end

endmodule

// File: tb/tb_io_input_reader.sv
// Scoreboard bench for io_input_reader: expected read data is queued when a
// read strobe is driven and compared when dout_valid appears.
module tb_io_input_reader;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [15:0] raw_in;
  logic [1:0]  coin_n;
  logic        cs;
  logic        rd;
  logic [1:0]  addr;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        coin_irq;

  int checks;
  int failures;
  int valid_count;
  int base;
  logic [7:0] sb [$];

  io_input_reader #(.DB_COUNT(4), .DBW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .raw_in     (raw_in),
    .coin_n     (coin_n),
    .cs         (cs),
    .rd         (rd),
    .addr       (addr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .coin_irq   (coin_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept lands on the next edge; drains the scoreboard entry afterwards
  task automatic read_reg(input logic [1:0] a, input logic [7:0] exp);
    addr = a;
    cs   = 1'b1;
    rd   = 1'b1;
    sb.push_back(exp);
    tick();
    cs = 1'b0;
    rd = 1'b0;
    repeat (3) tick();
    check("read_drain", sb.size(), 0);
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (dout_valid) begin
      valid_count++;
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        check("dout", dout, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks      = 0;
    failures    = 0;
    valid_count = 0;
    rst    = 1'b1;
    ce     = 1'b1;
    raw_in = 16'h0000;
    coin_n = 2'b11;
    cs     = 1'b0;
    rd     = 1'b0;
    addr   = 2'd0;

    // Reset with all inputs asserted; stable must start at 1
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_dout", dout, 8'hFF);
    check("rst_valid", dout_valid, 0);
    check("rst_irq", coin_irq, 0);
    read_reg(2'd0, 8'hFF);          // accept at 1st edge after release
    tick();
    read_reg(2'd0, 8'hFF);          // accept at 6th edge: still inactive
    read_reg(2'd0, 8'h00);          // accept at 10th edge
    read_reg(2'd1, 8'h00);
    raw_in = 16'hFFFF;
    repeat (10) tick();

    // Distinct pattern on both ports
    raw_in = 16'h3C5A;
    repeat (10) tick();
    read_reg(2'd0, 8'h5A);
    read_reg(2'd1, 8'h3C);
    raw_in = 16'hFFFF;
    repeat (10) tick();

    // Latency boundary: input low before edge 0, accept at edge 5 vs edge 6
    raw_in[0] = 1'b0;
    repeat (5) tick();
    read_reg(2'd0, 8'hFF);
    raw_in[0] = 1'b1;
    repeat (12) tick();
    raw_in[0] = 1'b0;
    repeat (6) tick();
    read_reg(2'd0, 8'hFE);
    raw_in[0] = 1'b1;
    repeat (12) tick();

    // Three-clock glitch is rejected
    raw_in[9] = 1'b0;
    repeat (3) tick();
    raw_in[9] = 1'b1;
    read_reg(2'd1, 8'hFF);
    repeat (5) tick();
    read_reg(2'd1, 8'hFF);

    // ce every 4th clock: stable changes at edge 15, read before and after
    raw_in[1] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ce   = (i % 4 == 3);
      addr = 2'd0;
      cs   = (i == 15) || (i == 17);
      rd   = (i == 15) || (i == 17);
      if (i == 15) sb.push_back(8'hFF);
      if (i == 17) sb.push_back(8'hFD);
      tick();
    end
    ce = 1'b1;
    cs = 1'b0;
    rd = 1'b0;
    repeat (3) tick();
    check("ce_drain", sb.size(), 0);
    raw_in = 16'hFFFF;
    repeat (10) tick();

    // Coin 1: irq rises one edge after stable falls (stable falls at edge 5)
    coin_n[1] = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    check("irq_before", coin_irq, 0);
    tick();
    @(negedge clk);
    check("irq_rise", coin_irq, 1);
    read_reg(2'd2, 8'h02);
    check("irq_cleared", coin_irq, 0);
    read_reg(2'd2, 8'h00);
    read_reg(2'd3, 8'h01);
    coin_n[1] = 1'b1;
    repeat (10) tick();
    check("irq_idle", coin_irq, 0);

    // Coin 0 stable falls on the same edge as the addr-2 accept
    coin_n[0] = 1'b0;
    repeat (5) tick();
    read_reg(2'd2, 8'h00);
    check("collide_irq", coin_irq, 1);
    read_reg(2'd2, 8'h01);
    check("collide_irq_clr", coin_irq, 0);
    coin_n[0] = 1'b1;
    repeat (10) tick();

    // Port A all asserted so dout is not FF before the reset test
    raw_in = 16'hFF00;
    repeat (10) tick();
    read_reg(2'd0, 8'h00);

    // Held strobe yields one pulse
    base = valid_count;
    addr = 2'd0;
    cs   = 1'b1;
    rd   = 1'b1;
    sb.push_back(8'h00);
    repeat (10) tick();
    cs = 1'b0;
    rd = 1'b0;
    repeat (3) tick();
    check("held_pulses", valid_count - base, 1);
    check("held_drain", sb.size(), 0);

    // Reset on the accept edge: no pulse, dout back to FF
    base = valid_count;
    addr = 2'd0;
    cs   = 1'b1;
    rd   = 1'b1;
    rst  = 1'b1;
    tick();
    rst = 1'b0;
    cs  = 1'b0;
    rd  = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_mid_pulses", valid_count - base, 0);
    check("rst_mid_dout", dout, 8'hFF);
    check("rst_mid_irq", coin_irq, 0);
    check("final_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
